// File: rtl/video_window_calc_if.sv
// Signal bundle between the video timing / aspect stage (master) and video_window_calc (slave).
interface video_window_calc_if #(
    parameter int DW = 12
);
    logic          VGA_VS;
    logic [DW-1:0] HDMI_WIDTH;
    logic [DW-1:0] HDMI_HEIGHT;
    logic [DW:0]   VIDEO_ARX;
    logic [DW:0]   VIDEO_ARY;
    logic [DW-1:0] HMIN;
    logic [DW-1:0] HMAX;
    logic [DW-1:0] VMIN;
    logic [DW-1:0] VMAX;
    logic          WIN_VALID;
    logic          BUSY;
    logic [3:0]    fsm_state;

    modport master (
        output VGA_VS, HDMI_WIDTH, HDMI_HEIGHT, VIDEO_ARX, VIDEO_ARY,
        input  HMIN, HMAX, VMIN, VMAX, WIN_VALID, BUSY, fsm_state
    );

    modport slave (
        input  VGA_VS, HDMI_WIDTH, HDMI_HEIGHT, VIDEO_ARX, VIDEO_ARY,
        output HMIN, HMAX, VMIN, VMAX, WIN_VALID, BUSY, fsm_state
    );
endinterface

// File: rtl/video_window_calc.sv
// Computes the centred scaler output window from aspect ratio or exact size, committed on VGA_VS rise.
// Optional: define VIDEO_WINDOW_ALIGN_EN to round W/H down to multiples of 4 and force HMIN even.
module video_window_calc #(
    parameter int DW = 12
) (
    input  logic               CLK_VIDEO,
    input  logic               RESET_N,
    video_window_calc_if.slave win
);
    localparam int CW = $clog2(2 * DW);
    localparam logic [CW-1:0] MUL_LAST = CW'(DW - 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(2 * DW - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_LATCH, S_MUL1, S_DIV1, S_CMP, S_MUL2, S_DIV2, S_ALIGN, S_CENTER, S_PEND
    } state_t;

`ifdef VIDEO_WINDOW_ALIGN_EN
    localparam state_t S_FINISH = S_ALIGN;
`else
    localparam state_t S_FINISH = S_CENTER;
`endif

    state_t          state;
    logic [DW-1:0]   snap_w, snap_h;
    logic [DW:0]     snap_x, snap_y;
    logic [DW-1:0]   w_r, h_r;
    logic [2*DW-1:0] acc, mcand, dvd;
    logic [DW-1:0]   mplier, divisor, rem;
    logic [CW-1:0]   cnt;
    logic [DW-1:0]   sh_hmin, sh_hmax, sh_vmin, sh_vmax;
    logic [DW-1:0]   hmin_q, hmax_q, vmin_q, vmax_q;
    logic            win_valid_q, pending, vs_q;

    function automatic logic [DW-1:0] at_least_one(input logic [DW-1:0] v);
        return (v == '0) ? DW'(1) : v;
    endfunction

`ifdef VIDEO_WINDOW_ALIGN_EN
    function automatic logic [DW-1:0] align4(input logic [DW-1:0] v);
        return (v < DW'(4)) ? DW'(4) : (v & ~DW'(3));
    endfunction
`endif

    // Mode decode works on the live inputs; they equal the snapshot being loaded in LATCH.
    logic [DW-1:0] fx, fy, w_exact, h_exact;
    logic          changed, exact_mode, ratio_zero, raster_zero;

    assign fx          = win.VIDEO_ARX[DW-1:0];
    assign fy          = win.VIDEO_ARY[DW-1:0];
    assign changed     = {win.HDMI_WIDTH, win.HDMI_HEIGHT, win.VIDEO_ARX, win.VIDEO_ARY}
                         != {snap_w, snap_h, snap_x, snap_y};
    assign exact_mode  = win.VIDEO_ARX[DW] | win.VIDEO_ARY[DW];
    assign ratio_zero  = (fx == '0) || (fy == '0);
    assign raster_zero = (win.HDMI_WIDTH == '0) || (win.HDMI_HEIGHT == '0);
    assign w_exact     = (fx == '0 || fx > win.HDMI_WIDTH)  ? win.HDMI_WIDTH  : fx;
    assign h_exact     = (fy == '0 || fy > win.HDMI_HEIGHT) ? win.HDMI_HEIGHT : fy;

    // Shared shift-add multiplier and restoring divider (2*DW-bit dividend, DW-bit divisor).
    logic [2*DW-1:0] acc_add, dvd_nxt;
    logic [DW:0]     rem_sh;
    logic [DW-1:0]   rem_diff, rem_nxt;
    logic            rem_ge;

    assign acc_add  = mplier[0] ? acc + mcand : acc;
    assign rem_sh   = {rem, dvd[2*DW-1]};
    assign rem_ge   = rem_sh >= {1'b0, divisor};
    assign rem_diff = rem_sh[DW-1:0] - divisor;
    assign rem_nxt  = rem_ge ? rem_diff : rem_sh[DW-1:0];
    assign dvd_nxt  = {dvd[2*DW-2:0], rem_ge};

    logic [DW-1:0] hmin_c, vmin_c;
`ifdef VIDEO_WINDOW_ALIGN_EN
    assign hmin_c = ((snap_w - w_r) >> 1) & ~DW'(1);
`else
    assign hmin_c = (snap_w - w_r) >> 1;
`endif
    assign vmin_c = (snap_h - h_r) >> 1;

    logic vs_rise;
    assign vs_rise = win.VGA_VS & ~vs_q;

    // Commit protocol: a finished result waits in the shadow with pending set; the first
    // VGA_VS rising edge after that copies it to the outputs. The CENTER cycle never commits.
    always_ff @(posedge CLK_VIDEO or negedge RESET_N) begin
        if (!RESET_N) begin
            state       <= S_IDLE;
            snap_w      <= '0;
            snap_h      <= '0;
            snap_x      <= '0;
            snap_y      <= '0;
            w_r         <= '0;
            h_r         <= '0;
            acc         <= '0;
            mcand       <= '0;
            dvd         <= '0;
            mplier      <= '0;
            divisor     <= '0;
            rem         <= '0;
            cnt         <= '0;
            sh_hmin     <= '0;
            sh_hmax     <= '0;
            sh_vmin     <= '0;
            sh_vmax     <= '0;
            hmin_q      <= '0;
            hmax_q      <= '0;
            vmin_q      <= '0;
            vmax_q      <= '0;
            win_valid_q <= 1'b0;
            pending     <= 1'b0;
            vs_q        <= 1'b0;
        end else begin
            vs_q <= win.VGA_VS;
            if (vs_rise && pending && state != S_CENTER) begin
                hmin_q      <= sh_hmin;
                hmax_q      <= sh_hmax;
                vmin_q      <= sh_vmin;
                vmax_q      <= sh_vmax;
                win_valid_q <= 1'b1;
                pending     <= 1'b0;
            end

            if (changed && (state inside {S_MUL1, S_DIV1, S_CMP, S_MUL2, S_DIV2, S_ALIGN, S_CENTER})) begin
                state <= S_LATCH;
            end else begin
                case (state)
                    S_IDLE: if (changed) state <= S_LATCH;
                    S_LATCH: begin
                        snap_w <= win.HDMI_WIDTH;
                        snap_h <= win.HDMI_HEIGHT;
                        snap_x <= win.VIDEO_ARX;
                        snap_y <= win.VIDEO_ARY;
                        cnt    <= '0;
                        if (raster_zero) begin
                            state <= S_IDLE;
                        end else if (exact_mode) begin
                            w_r   <= w_exact;
                            h_r   <= h_exact;
                            state <= S_FINISH;
                        end else if (ratio_zero) begin
                            w_r   <= win.HDMI_WIDTH;
                            h_r   <= win.HDMI_HEIGHT;
                            state <= S_FINISH;
                        end else begin
                            acc     <= '0;
                            mcand   <= {{DW{1'b0}}, win.HDMI_HEIGHT};
                            mplier  <= fx;
                            divisor <= fy;
                            state   <= S_MUL1;
                        end
                    end
                    S_MUL1, S_MUL2: begin
                        acc    <= acc_add;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        cnt    <= cnt + 1'b1;
                        if (cnt == MUL_LAST) begin
                            dvd   <= acc_add;
                            rem   <= '0;
                            cnt   <= '0;
                            state <= (state == S_MUL1) ? S_DIV1 : S_DIV2;
                        end
                    end
                    S_DIV1, S_DIV2: begin
                        dvd <= dvd_nxt;
                        rem <= rem_nxt;
                        cnt <= cnt + 1'b1;
                        if (cnt == DIV_LAST) begin
                            cnt <= '0;
                            if (state == S_DIV1) begin
                                state <= S_CMP;
                            end else begin
                                h_r   <= at_least_one(dvd_nxt[DW-1:0]);
                                state <= S_FINISH;
                            end
                        end
                    end
                    S_CMP: begin
                        if (dvd <= {{DW{1'b0}}, snap_w}) begin
                            w_r   <= at_least_one(dvd[DW-1:0]);
                            h_r   <= snap_h;
                            state <= S_FINISH;
                        end else begin
                            // Height-limited by width: H = HDMI_WIDTH * ARY / ARX.
                            w_r     <= snap_w;
                            acc     <= '0;
                            mcand   <= {{DW{1'b0}}, snap_w};
                            mplier  <= snap_y[DW-1:0];
                            divisor <= snap_x[DW-1:0];
                            state   <= S_MUL2;
                        end
                    end
`ifdef VIDEO_WINDOW_ALIGN_EN
                    S_ALIGN: begin
                        w_r   <= align4(w_r);
                        h_r   <= align4(h_r);
                        state <= S_CENTER;
                    end
`endif
                    S_CENTER: begin
                        sh_hmin <= hmin_c;
                        sh_hmax <= hmin_c + w_r - 1'b1;
                        sh_vmin <= vmin_c;
                        sh_vmax <= vmin_c + h_r - 1'b1;
                        pending <= 1'b1;
                        state   <= S_PEND;
                    end
                    S_PEND:  state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign win.HMIN      = hmin_q;
    assign win.HMAX      = hmax_q;
    assign win.VMIN      = vmin_q;
    assign win.VMAX      = vmax_q;
    assign win.WIN_VALID = win_valid_q;
    assign win.BUSY      = (state != S_IDLE) && (state != S_PEND);
    assign win.fsm_state = state;
endmodule

// File: tb/tb_video_window_calc.sv
// Self-checking bench for video_window_calc: directed cases plus randomized windows vs. a reference model.
module tb_video_window_calc;
    localparam int DW = 12;
`ifdef VIDEO_WINDOW_ALIGN_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    video_window_calc_if #(.DW(DW)) bus ();
    video_window_calc #(.DW(DW)) dut (.CLK_VIDEO(clk), .RESET_N(rst_n), .win(bus));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [4*DW-1:0] exp_q[$];
    logic [4*DW-1:0] cur_win   = '0;
    logic            cur_valid = 1'b0;

    // Reference: window from the aspect/exact rules, using plain integer arithmetic.
    function automatic logic [4*DW-1:0] model(input int hw, input int hh,
                                               input logic [DW:0] arx, input logic [DW:0] ary);
        int fx, fy, w, h, hmin, vmin;
        longint wc;
        fx = int'(arx[DW-1:0]);
        fy = int'(ary[DW-1:0]);
        if (arx[DW] || ary[DW]) begin
            w = (fx == 0 || fx > hw) ? hw : fx;
            h = (fy == 0 || fy > hh) ? hh : fy;
        end else if (fx == 0 || fy == 0) begin
            w = hw;
            h = hh;
        end else begin
            wc = (longint'(hh) * fx) / fy;
            if (wc <= hw) begin
                w = int'(wc);
                h = hh;
            end else begin
                w = hw;
                h = int'((longint'(hw) * fy) / fx);
            end
        end
        if (w < 1) w = 1;
        if (h < 1) h = 1;
`ifdef VIDEO_WINDOW_ALIGN_EN
        w = (w < 4) ? 4 : w - (w % 4);
        h = (h < 4) ? 4 : h - (h % 4);
`endif
        hmin = (hw - w) / 2;
        vmin = (hh - h) / 2;
`ifdef VIDEO_WINDOW_ALIGN_EN
        hmin = hmin - (hmin % 2);
`endif
        return {DW'(hmin), DW'(hmin + w - 1), DW'(vmin), DW'(vmin + h - 1)};
    endfunction

    function automatic string win_str(input logic [4*DW-1:0] v);
        return $sformatf("%0d/%0d/%0d/%0d", v[4*DW-1:3*DW], v[3*DW-1:2*DW], v[2*DW-1:DW], v[DW-1:0]);
    endfunction

    function automatic logic [4*DW-1:0] dut_win();
        return {bus.HMIN, bus.HMAX, bus.VMIN, bus.VMAX};
    endfunction

    // Drive inputs now; a computable raster makes the model result the only pending one.
    task automatic drive(input int hw, input int hh, input logic [DW:0] x, input logic [DW:0] y);
        bus.HDMI_WIDTH  = DW'(hw);
        bus.HDMI_HEIGHT = DW'(hh);
        bus.VIDEO_ARX   = x;
        bus.VIDEO_ARY   = y;
        if (hw != 0 && hh != 0) begin
            exp_q.delete();
            exp_q.push_back(model(hw, hh, x, y));
        end
    endtask

    task automatic apply(input int hw, input int hh, input logic [DW:0] x, input logic [DW:0] y);
        @(negedge clk);
        drive(hw, hh, x, y);
    endtask

    task automatic wait_done(output int n, output bit ok);
        bit seen;
        n = 0; seen = 0; ok = 0;
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            if (bus.BUSY) begin
                n++;
                seen = 1;
            end else if (seen) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic pulse_vs();
        @(negedge clk);
        bus.VGA_VS = 1'b1;
        @(negedge clk);
        bus.VGA_VS = 1'b0;
        if (exp_q.size() > 0) begin
            cur_win   = exp_q.pop_front();
            cur_valid = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if (dut_win() !== '0 || bus.WIN_VALID !== 1'b0 || bus.BUSY !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got win %s valid %b busy %b, want 0/0/0/0 valid 0 busy 0",
                     win_str(dut_win()), bus.WIN_VALID, bus.BUSY);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (bus.BUSY !== 1'b0 || bus.WIN_VALID !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got busy %b valid %b, want 0 0", bus.BUSY, bus.WIN_VALID);
        end
    endtask

    task automatic test_window_modes();
        logic [DW:0] xs [5] = '{13'd4, 13'd21, 13'h1500, 13'd0, 13'h1FFF};
        logic [DW:0] ys [5] = '{13'd3, 13'd9, 13'h13C0, 13'd3, 13'h1000};
        int lat [5] = '{39, 75, 2, 2, 2};
        int n;
        bit ok;
        for (int i = 0; i < 5; i++) begin
            apply(1920, 1080, xs[i], ys[i]);
            wait_done(n, ok);
            checks++;
            if (!ok || n != lat[i] + EXTRA) begin
                errors++;
                $display("FAIL mode%0d_busy: got %0d cycles done %0d, want %0d", i, n, ok, lat[i] + EXTRA);
            end
            checks++;
            if (dut_win() !== cur_win || bus.WIN_VALID !== cur_valid) begin
                errors++;
                $display("FAIL mode%0d_held: got %s valid %b, want %s valid %b", i,
                         win_str(dut_win()), bus.WIN_VALID, win_str(cur_win), cur_valid);
            end
            pulse_vs();
            checks++;
            if (dut_win() !== cur_win || bus.WIN_VALID !== 1'b1) begin
                errors++;
                $display("FAIL mode%0d_commit: got %s valid %b, want %s valid 1", i,
                         win_str(dut_win()), bus.WIN_VALID, win_str(cur_win));
            end
        end
    endtask

    task automatic test_raster_zero();
        int n;
        bit ok;
        apply(0, 1080, 13'd5, 13'd3);
        wait_done(n, ok);
        checks++;
        if (!ok || n != 1) begin
            errors++;
            $display("FAIL raster_zero_busy: got %0d cycles done %0d, want 1", n, ok);
        end
        pulse_vs();
        checks++;
        if (dut_win() !== cur_win || bus.WIN_VALID !== cur_valid) begin
            errors++;
            $display("FAIL raster_zero_held: got %s, want %s", win_str(dut_win()), win_str(cur_win));
        end
    endtask

    task automatic test_back_to_back();
        int n;
        bit ok;
        apply(1920, 1080, 13'h1320, 13'h1258);
        wait_done(n, ok);
        apply(1920, 1080, 13'd1, 13'd1);
        wait_done(n, ok);
        checks++;
        if (!ok || dut_win() !== cur_win) begin
            errors++;
            $display("FAIL latest_held: got %s done %0d, want %s", win_str(dut_win()), ok, win_str(cur_win));
        end
        pulse_vs();
        checks++;
        if (dut_win() !== cur_win) begin
            errors++;
            $display("FAIL latest_commit: got %s, want %s", win_str(dut_win()), win_str(cur_win));
        end
    endtask

    task automatic test_abort();
        int n;
        bit ok, seen, held;
        apply(1920, 1080, 13'd16, 13'd3);
        seen = 0;
        for (int t = 0; t < 20 && !seen; t++) begin
            @(negedge clk);
            seen = bus.BUSY;
        end
        repeat (32) @(negedge clk);
        drive(1920, 1080, 13'd16, 13'd9);
        held = 1;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (dut_win() !== cur_win) held = 0;
        end
        wait_done(n, ok);
        checks++;
        if (!seen || !ok || !held || dut_win() !== cur_win) begin
            errors++;
            $display("FAIL abort_held: got %s busy_seen %0d done %0d held %0d, want %s",
                     win_str(dut_win()), seen, ok, held, win_str(cur_win));
        end
        pulse_vs();
        checks++;
        if (dut_win() !== cur_win) begin
            errors++;
            $display("FAIL abort_commit: got %s, want %s", win_str(dut_win()), win_str(cur_win));
        end
    endtask

    task automatic test_vs_center();
        apply(1920, 1080, 13'h1280, 13'h11E0);
        @(negedge clk);
        repeat (1 + EXTRA) @(negedge clk);
        bus.VGA_VS = 1'b1;
        @(negedge clk);
        checks++;
        if (dut_win() !== cur_win || bus.WIN_VALID !== cur_valid) begin
            errors++;
            $display("FAIL vs_center_held: got %s, want %s", win_str(dut_win()), win_str(cur_win));
        end
        @(negedge clk);
        bus.VGA_VS = 1'b0;
        @(negedge clk);
        checks++;
        if (dut_win() !== cur_win) begin
            errors++;
            $display("FAIL vs_level_held: got %s, want %s", win_str(dut_win()), win_str(cur_win));
        end
        pulse_vs();
        checks++;
        if (dut_win() !== cur_win) begin
            errors++;
            $display("FAIL vs_center_next: got %s, want %s", win_str(dut_win()), win_str(cur_win));
        end
    endtask

    task automatic test_async_reset();
        int n;
        bit ok, seen;
        apply(1920, 1080, 13'd21, 13'd9);
        seen = 0;
        for (int t = 0; t < 20 && !seen; t++) begin
            @(negedge clk);
            seen = bus.BUSY;
        end
        repeat (59) @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        cur_win   = '0;
        cur_valid = 1'b0;
        drive(1920, 1080, 13'd4, 13'd3);
        #1;
        checks++;
        if (!seen || dut_win() !== '0 || bus.WIN_VALID !== 1'b0 || bus.BUSY !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got %s valid %b busy %b busy_seen %0d, want 0/0/0/0 valid 0 busy 0",
                     win_str(dut_win()), bus.WIN_VALID, bus.BUSY, seen);
        end
        @(negedge clk);
        rst_n = 1'b1;
        wait_done(n, ok);
        checks++;
        if (!ok || n != 39 + EXTRA || bus.WIN_VALID !== 1'b0) begin
            errors++;
            $display("FAIL reset_recompute: got %0d cycles done %0d valid %b, want %0d valid 0",
                     n, ok, bus.WIN_VALID, 39 + EXTRA);
        end
        pulse_vs();
        checks++;
        if (dut_win() !== cur_win || bus.WIN_VALID !== 1'b1) begin
            errors++;
            $display("FAIL reset_commit: got %s valid %b, want %s valid 1",
                     win_str(dut_win()), bus.WIN_VALID, win_str(cur_win));
        end
    endtask

    task automatic test_random();
        int hw, hh, n, mode;
        logic [DW:0] x, y;
        bit ok;
        for (int i = 0; i < 24; i++) begin
            hw   = $urandom_range(64, 4095);
            hh   = $urandom_range(64, 4095);
            mode = $urandom_range(0, 3);
            x    = 13'($urandom_range(1, 64));
            y    = 13'($urandom_range(1, 64));
            if (mode == 2) begin
                x = {1'b1, 12'($urandom_range(0, 4095))};
                y = {1'($urandom_range(0, 1)), 12'($urandom_range(0, 4095))};
            end else if (mode == 3) begin
                if ($urandom_range(0, 1) == 1) x = '0;
                else y = '0;
            end
            if (DW'(hw) == bus.HDMI_WIDTH && DW'(hh) == bus.HDMI_HEIGHT && x == bus.VIDEO_ARX && y == bus.VIDEO_ARY)
                hw = (hw == 4095) ? 4094 : hw + 1;
            apply(hw, hh, x, y);
            wait_done(n, ok);
            checks++;
            if (!ok || dut_win() !== cur_win) begin
                errors++;
                $display("FAIL rand%0d_held: got %s done %0d, want %s", i, win_str(dut_win()), ok, win_str(cur_win));
            end
            pulse_vs();
            checks++;
            if (dut_win() !== cur_win || bus.WIN_VALID !== 1'b1) begin
                errors++;
                $display("FAIL rand%0d_commit: in %0dx%0d arx %h ary %h got %s valid %b, want %s",
                         i, hw, hh, x, y, win_str(dut_win()), bus.WIN_VALID, win_str(cur_win));
            end
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.VGA_VS      = 1'b0;
        bus.HDMI_WIDTH  = '0;
        bus.HDMI_HEIGHT = '0;
        bus.VIDEO_ARX   = '0;
        bus.VIDEO_ARY   = '0;
        test_reset();
        test_window_modes();
        test_raster_zero();
        test_back_to_back();
        test_abort();
        test_vs_center();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
